up_counter: RTL and testbench

UP_COUNTER -- requirements
Module: up_counter

---
 rtl/up_counter.sv | 99 +++++++++
 tb/tb_up_counter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/up_counter.sv
// Run/pause up-counter, 0..16 count shown on a 16-LED thermometer bar, one step per TICK_DIV clocks.
// Define UP_COUNTER_WRAP_EN to wrap 16 -> 0 and keep running instead of stopping in the full state.
module up_counter #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pulse,
  input  logic        clr_pulse,
  output logic [15:0] led,
  output logic        full
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StFull} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    count_q, count_d;
  logic [15:0]   led_d;
  logic [16:0]   therm;
  logic          full_d;
  logic          tick;

  // The tick is combinational so the count, led and full all update on the edge that samples it.
  assign tick = (state_q == StRun) && (presc_q == PrescLast);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    if (clr_pulse) begin
      state_d = StIdle;
      presc_d = '0;
      count_d = 5'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          presc_d = '0;
          count_d = 5'd0;
          if (start_pulse) state_d = StRun;
        end
        StRun: begin
          if (tick) begin
            presc_d = '0;
`ifdef UP_COUNTER_WRAP_EN
            count_d = (count_q == 5'd16) ? 5'd0 : count_q + 5'd1;
            if (start_pulse) state_d = StPause;
`else
            count_d = count_q + 5'd1;
            if (count_d == 5'd16) state_d = StFull;
            else if (start_pulse) state_d = StPause;
`endif
          end else begin
            presc_d = presc_q + PW'(1);
            if (start_pulse) state_d = StPause;
          end
        end
        StPause: begin
          if (start_pulse) state_d = StRun;
        end
        StFull: begin
          presc_d = '0;
          count_d = 5'd16;
        end
        default: begin
          state_d = StIdle;
          presc_d = '0;
          count_d = 5'd0;
        end
      endcase
    end
  end

  always_comb begin
    therm  = (17'h1 << count_d) - 17'h1;
    led_d  = therm[15:0];
    full_d = (count_d == 5'd16);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      count_q <= 5'd0;
      led     <= 16'h0000;
      full    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      led     <= led_d;
      full    <= full_d;
    end
  end

endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter with TICK_DIV=4: count k appears 4*k edges after the start edge.
module tb_up_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_pulse = 1'b0;
  logic        clr_pulse = 1'b0;
  logic [15:0] led;
  logic        full;

  int n_cmp = 0;
  int n_err = 0;

  up_counter #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_pulse (start_pulse),
    .clr_pulse   (clr_pulse),
    .led         (led),
    .full        (full)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_pulse = 1'b1;
    @(negedge clk);
    clr_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_pulse = 1'b1;
    wait_cyc(2);
    start_pulse = 1'b0;
    rst = 1'b0;
    n_cmp++;
    if (led !== 16'h0000) begin
      n_err++; $display("FAIL reset_led got=%h want=%h", led, 16'h0000);
    end
    n_cmp++;
    if (full !== 1'b0) begin
      n_err++; $display("FAIL reset_full got=%b want=%b", full, 1'b0);
    end
    wait_cyc(20);
    n_cmp++;
    if (led !== 16'h0000 || full !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_hold got=%h/%b want=%h/%b", led, full, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_count_pause();
    pulse_start();                 // start edge E0
    wait_cyc(11);                  // E11: count 2
    n_cmp++;
    if (led !== 16'h0003) begin
      n_err++; $display("FAIL count_e11 got=%h want=%h", led, 16'h0003);
    end
    wait_cyc(1);                   // E12: count 3
    n_cmp++;
    if (led !== 16'h0007) begin
      n_err++; $display("FAIL count_e12 got=%h want=%h", led, 16'h0007);
    end
    pulse_start();                 // pause with prescaler frozen at 1
    wait_cyc(20);
    n_cmp++;
    if (led !== 16'h0007) begin
      n_err++; $display("FAIL pause_hold got=%h want=%h", led, 16'h0007);
    end
    pulse_start();                 // resume edge R, prescaler 1
    wait_cyc(2);                   // R+2: prescaler 3, no increment yet
    n_cmp++;
    if (led !== 16'h0007) begin
      n_err++; $display("FAIL resume_early got=%h want=%h", led, 16'h0007);
    end
    wait_cyc(1);                   // R+3: count 4
    n_cmp++;
    if (led !== 16'h000F) begin
      n_err++; $display("FAIL resume_step got=%h want=%h", led, 16'h000F);
    end
  endtask

  task automatic test_full();
    pulse_clr();
    pulse_start();
    wait_cyc(63);                  // E63: count 15
    n_cmp++;
    if (led !== 16'h7FFF || full !== 1'b0) begin
      n_err++; $display("FAIL count_15 got=%h/%b want=%h/%b", led, full, 16'h7FFF, 1'b0);
    end
    wait_cyc(1);                   // E64: count 16
    n_cmp++;
    if (led !== 16'hFFFF || full !== 1'b1) begin
      n_err++; $display("FAIL count_16 got=%h/%b want=%h/%b", led, full, 16'hFFFF, 1'b1);
    end
`ifdef UP_COUNTER_WRAP_EN
    wait_cyc(3);
    n_cmp++;
    if (led !== 16'hFFFF || full !== 1'b1) begin
      n_err++; $display("FAIL wrap_before got=%h/%b want=%h/%b", led, full, 16'hFFFF, 1'b1);
    end
    wait_cyc(1);                   // E68: wraps to 0
    n_cmp++;
    if (led !== 16'h0000 || full !== 1'b0) begin
      n_err++; $display("FAIL wrap_zero got=%h/%b want=%h/%b", led, full, 16'h0000, 1'b0);
    end
    wait_cyc(4);                   // E72: still counting
    n_cmp++;
    if (led !== 16'h0001) begin
      n_err++; $display("FAIL wrap_continue got=%h want=%h", led, 16'h0001);
    end
`else
    wait_cyc(10);
    n_cmp++;
    if (led !== 16'hFFFF || full !== 1'b1) begin
      n_err++; $display("FAIL full_hold got=%h/%b want=%h/%b", led, full, 16'hFFFF, 1'b1);
    end
    pulse_start();
    wait_cyc(8);
    n_cmp++;
    if (led !== 16'hFFFF || full !== 1'b1) begin
      n_err++; $display("FAIL full_start_ignored got=%h/%b want=%h/%b", led, full, 16'hFFFF, 1'b1);
    end
`endif
    pulse_clr();
    n_cmp++;
    if (led !== 16'h0000 || full !== 1'b0) begin
      n_err++; $display("FAIL full_clr got=%h/%b want=%h/%b", led, full, 16'h0000, 1'b0);
    end
    wait_cyc(10);
    n_cmp++;
    if (led !== 16'h0000) begin
      n_err++; $display("FAIL full_clr_idle got=%h want=%h", led, 16'h0000);
    end
  endtask

  task automatic test_clr_start_same();
    pulse_clr();
    pulse_start();
    wait_cyc(20);                  // E20: count 5
    n_cmp++;
    if (led !== 16'h001F) begin
      n_err++; $display("FAIL count_5 got=%h want=%h", led, 16'h001F);
    end
    start_pulse = 1'b1;
    clr_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    clr_pulse = 1'b0;
    n_cmp++;
    if (led !== 16'h0000 || full !== 1'b0) begin
      n_err++; $display("FAIL clr_wins got=%h/%b want=%h/%b", led, full, 16'h0000, 1'b0);
    end
    wait_cyc(20);
    n_cmp++;
    if (led !== 16'h0000) begin
      n_err++; $display("FAIL clr_wins_idle got=%h want=%h", led, 16'h0000);
    end
  endtask

  task automatic test_tick_start();
    pulse_clr();
    pulse_start();
    wait_cyc(3);                   // E3: prescaler 3, tick pending
    n_cmp++;
    if (led !== 16'h0000) begin
      n_err++; $display("FAIL pre_tick got=%h want=%h", led, 16'h0000);
    end
    pulse_start();                 // E4: tick and start together
    n_cmp++;
    if (led !== 16'h0001) begin
      n_err++; $display("FAIL tick_start_inc got=%h want=%h", led, 16'h0001);
    end
    wait_cyc(10);
    n_cmp++;
    if (led !== 16'h0001) begin
      n_err++; $display("FAIL tick_start_paused got=%h want=%h", led, 16'h0001);
    end
    pulse_start();                 // resume edge R, prescaler 0
    wait_cyc(3);
    n_cmp++;
    if (led !== 16'h0001) begin
      n_err++; $display("FAIL tick_resume_early got=%h want=%h", led, 16'h0001);
    end
    wait_cyc(1);                   // R+4: count 2
    n_cmp++;
    if (led !== 16'h0003) begin
      n_err++; $display("FAIL tick_resume_step got=%h want=%h", led, 16'h0003);
    end
  endtask

  task automatic test_held_start();
    pulse_clr();
    start_pulse = 1'b1;            // two high cycles: run then pause
    wait_cyc(2);
    start_pulse = 1'b0;
    wait_cyc(12);
    n_cmp++;
    if (led !== 16'h0000) begin
      n_err++; $display("FAIL held_start_paused got=%h want=%h", led, 16'h0000);
    end
    pulse_start();                 // resume edge R, prescaler 1
    wait_cyc(3);                   // R+3: count 1
    n_cmp++;
    if (led !== 16'h0001) begin
      n_err++; $display("FAIL held_start_resume got=%h want=%h", led, 16'h0001);
    end
  endtask

  task automatic test_reset_mid();
    pulse_clr();
    pulse_start();
    wait_cyc(36);                  // E36: count 9
    n_cmp++;
    if (led !== 16'h01FF) begin
      n_err++; $display("FAIL count_9 got=%h want=%h", led, 16'h01FF);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (led !== 16'h0000 || full !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got=%h/%b want=%h/%b", led, full, 16'h0000, 1'b0);
    end
    wait_cyc(20);
    n_cmp++;
    if (led !== 16'h0000) begin
      n_err++; $display("FAIL mid_reset_idle got=%h want=%h", led, 16'h0000);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_pause();
    test_full();
    test_clr_start_same();
    test_tick_start();
    test_held_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
